// File: rtl/pieo_datatypes.sv
// Shared definitions for the PIEO sublist engine.
//   op_e        : operation encoding carried on op_type
//   DEF_*       : default widths/depth used as module parameter defaults
package pieo_datatypes;

  typedef enum logic [1:0] {
    OP_ENQ      = 2'd0,
    OP_DEQ_ELIG = 2'd1,
    OP_DEQ_ID   = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_ID_W   = 6;
  localparam int unsigned DEF_RANK_W = 16;
  localparam int unsigned DEF_TIME_W = 16;

endpackage

// File: rtl/pieo_time_cmp.sv
// Eligibility comparator: is send_time reached at cur_time?
//   send_time : element send time
//   cur_time  : current time
//   eligible  : 1 when the element may be dequeued
// WRAP_TIME=0 compares plainly; WRAP_TIME=1 treats times as a wrapping
// counter and calls send_time eligible when it lies within the past half range.
module pieo_time_cmp #(
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned WRAP_TIME = 0
) (
  input  logic [TIME_W-1:0] send_time,
  input  logic [TIME_W-1:0] cur_time,
  output logic              eligible
);

  generate
    if (WRAP_TIME != 0) begin : g_wrap
      logic [TIME_W-1:0] diff;
      assign diff     = cur_time - send_time;
      assign eligible = ~diff[TIME_W-1];
    end else begin : g_lin
      assign eligible = (send_time <= cur_time);
    end
  endgenerate

endmodule

// File: rtl/pieo_sublist_engine.sv
// PIEO sublist engine: a rank-sorted list of up to DEPTH entries supporting
// enqueue, dequeue of the first eligible entry, and dequeue by id.
// Ports:
//   clk, rst (sync, active-low), flush (empties list, aborts op)
//   op_valid/op_ready/op_type/op_id/op_rank/op_send_time/cur_time : request
//   res_valid/res_err/res_id/res_rank/res_send_time                : result
//   sum_smallest_rank/sum_smallest_send_time/sum_full/sum_num      : summaries
// Each op runs IDLE -> SEARCH -> UPDATE; result strobes two cycles after accept.
module pieo_sublist_engine
  import pieo_datatypes::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ID_W      = DEF_ID_W,
  parameter int unsigned RANK_W    = DEF_RANK_W,
  parameter int unsigned TIME_W    = DEF_TIME_W,
  parameter int unsigned WRAP_TIME = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 op_type,
  input  logic [ID_W-1:0]            op_id,
  input  logic [RANK_W-1:0]          op_rank,
  input  logic [TIME_W-1:0]          op_send_time,
  input  logic [TIME_W-1:0]          cur_time,
  output logic                       res_valid,
  output logic                       res_err,
  output logic [ID_W-1:0]            res_id,
  output logic [RANK_W-1:0]          res_rank,
  output logic [TIME_W-1:0]          res_send_time,
  output logic [RANK_W-1:0]          sum_smallest_rank,
  output logic [TIME_W-1:0]          sum_smallest_send_time,
  output logic                       sum_full,
  output logic [$clog2(DEPTH+1)-1:0] sum_num
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_UPDATE} state_e;

  state_e              state_q;
  op_e                 op_q;
  logic [ID_W-1:0]     op_id_q;
  logic [RANK_W-1:0]   op_rank_q;
  logic [TIME_W-1:0]   op_time_q;
  logic [TIME_W-1:0]   cur_q;

  logic [ID_W-1:0]     id_q   [DEPTH];
  logic [RANK_W-1:0]   rank_q [DEPTH];
  logic [TIME_W-1:0]   time_q [DEPTH];
  logic [CNT_W-1:0]    num_q;

  logic [DEPTH-1:0]    elig_raw;
  logic [DEPTH-1:0]    sel_vec;
  logic [IDX_W-1:0]    pos_d, pos_q;
  logic                hit_d, hit_q;

  logic [ID_W-1:0]     n_id   [DEPTH];
  logic [RANK_W-1:0]   n_rank [DEPTH];
  logic [TIME_W-1:0]   n_time [DEPTH];
  logic [CNT_W-1:0]    n_num;
  logic [TIME_W-1:0]   n_min_time;
  logic [ID_W-1:0]     r_id;
  logic [RANK_W-1:0]   r_rank;
  logic [TIME_W-1:0]   r_time;

  assign op_ready = (state_q == ST_IDLE) && !flush;
  assign sum_num  = num_q;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      pieo_time_cmp #(
        .TIME_W   (TIME_W),
        .WRAP_TIME(WRAP_TIME)
      ) u_cmp (
        .send_time(time_q[g]),
        .cur_time (cur_q),
        .eligible (elig_raw[g])
      );
    end
  endgenerate

  // Per-slot candidate vector for the latched op, masked to valid slots.
  always_comb begin
    sel_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < num_q) begin
        case (op_q)
          OP_ENQ:      sel_vec[i] = (rank_q[i] > op_rank_q);
          OP_DEQ_ELIG: sel_vec[i] = elig_raw[i];
          OP_DEQ_ID:   sel_vec[i] = (id_q[i] == op_id_q);
          default:     sel_vec[i] = 1'b0;
        endcase
      end
    end
  end

  // Lowest set index wins; ENQ with no larger rank appends at num.
  always_comb begin
    pos_d = IDX_W'(num_q);
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (sel_vec[i-1]) pos_d = IDX_W'(i - 1);
    end
    case (op_q)
      OP_ENQ:                 hit_d = (num_q != CNT_W'(DEPTH));
      OP_DEQ_ELIG, OP_DEQ_ID: hit_d = |sel_vec;
      default:                hit_d = 1'b0;
    endcase
  end

  // Post-update storage image; summaries are derived from it so they land
  // on the same edge as the shift.
  always_comb begin
    n_id   = id_q;
    n_rank = rank_q;
    n_time = time_q;
    n_num  = num_q;
    r_id   = '0;
    r_rank = '0;
    r_time = '0;
    if (hit_q) begin
      case (op_q)
        OP_ENQ: begin
          for (int unsigned i = 1; i < DEPTH; i++) begin
            if (IDX_W'(i) > pos_q) begin
              n_id[i]   = id_q[i-1];
              n_rank[i] = rank_q[i-1];
              n_time[i] = time_q[i-1];
            end
          end
          n_id[pos_q]   = op_id_q;
          n_rank[pos_q] = op_rank_q;
          n_time[pos_q] = op_time_q;
          n_num         = num_q + CNT_W'(1);
          r_id          = op_id_q;
          r_rank        = op_rank_q;
          r_time        = op_time_q;
        end
        OP_DEQ_ELIG, OP_DEQ_ID: begin
          r_id   = id_q[pos_q];
          r_rank = rank_q[pos_q];
          r_time = time_q[pos_q];
          for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (IDX_W'(i) >= pos_q) begin
              n_id[i]   = id_q[i+1];
              n_rank[i] = rank_q[i+1];
              n_time[i] = time_q[i+1];
            end
          end
          n_num = num_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
    n_min_time = '1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < n_num) && (n_time[i] < n_min_time)) n_min_time = n_time[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                <= ST_IDLE;
      num_q                  <= '0;
      op_q                   <= OP_ENQ;
      op_id_q                <= '0;
      op_rank_q              <= '0;
      op_time_q              <= '0;
      cur_q                  <= '0;
      pos_q                  <= '0;
      hit_q                  <= 1'b0;
      res_valid              <= 1'b0;
      res_err                <= 1'b0;
      res_id                 <= '0;
      res_rank               <= '0;
      res_send_time          <= '0;
      sum_smallest_rank      <= '1;
      sum_smallest_send_time <= '1;
      sum_full               <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (flush) begin
        state_q                <= ST_IDLE;
        num_q                  <= '0;
        sum_smallest_rank      <= '1;
        sum_smallest_send_time <= '1;
        sum_full               <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (op_valid) begin
              op_q      <= op_e'(op_type);
              op_id_q   <= op_id;
              op_rank_q <= op_rank;
              op_time_q <= op_send_time;
              cur_q     <= cur_time;
              state_q   <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            pos_q   <= pos_d;
            hit_q   <= hit_d;
            state_q <= ST_UPDATE;
          end
          ST_UPDATE: begin
            id_q                   <= n_id;
            rank_q                 <= n_rank;
            time_q                 <= n_time;
            num_q                  <= n_num;
            sum_smallest_rank      <= (n_num == '0) ? '1 : n_rank[0];
            sum_smallest_send_time <= n_min_time;
            sum_full               <= (n_num == CNT_W'(DEPTH));
            res_valid              <= 1'b1;
            res_err                <= !hit_q;
            res_id                 <= r_id;
            res_rank               <= r_rank;
            res_send_time          <= r_time;
            state_q                <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pieo_sublist_engine.sv
// Self-checking bench: two engines (WRAP_TIME=0 and =1) share one stimulus
// stream and are each compared against a queue-based reference list.
module tb_pieo_sublist_engine;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [5:0]  id;
    logic [15:0] rank;
    logic [15:0] st;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [5:0]  op_id;
  logic [15:0] op_rank;
  logic [15:0] op_send_time;
  logic [15:0] cur_time;

  logic        op_ready_o  [2];
  logic        res_valid_o [2];
  logic        res_err_o   [2];
  logic [5:0]  res_id_o    [2];
  logic [15:0] res_rank_o  [2];
  logic [15:0] res_time_o  [2];
  logic [15:0] srank_o     [2];
  logic [15:0] stime_o     [2];
  logic        full_o      [2];
  logic [3:0]  num_o       [2];

  ent_t mq [2][$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pieo_sublist_engine #(
    .DEPTH(8), .ID_W(6), .RANK_W(16), .TIME_W(16), .WRAP_TIME(0)
  ) u_lin (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ready(op_ready_o[0]),
    .op_type(op_type), .op_id(op_id), .op_rank(op_rank), .op_send_time(op_send_time),
    .cur_time(cur_time), .res_valid(res_valid_o[0]), .res_err(res_err_o[0]),
    .res_id(res_id_o[0]), .res_rank(res_rank_o[0]), .res_send_time(res_time_o[0]),
    .sum_smallest_rank(srank_o[0]), .sum_smallest_send_time(stime_o[0]),
    .sum_full(full_o[0]), .sum_num(num_o[0])
  );

  pieo_sublist_engine #(
    .DEPTH(8), .ID_W(6), .RANK_W(16), .TIME_W(16), .WRAP_TIME(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ready(op_ready_o[1]),
    .op_type(op_type), .op_id(op_id), .op_rank(op_rank), .op_send_time(op_send_time),
    .cur_time(cur_time), .res_valid(res_valid_o[1]), .res_err(res_err_o[1]),
    .res_id(res_id_o[1]), .res_rank(res_rank_o[1]), .res_send_time(res_time_o[1]),
    .sum_smallest_rank(srank_o[1]), .sum_smallest_send_time(stime_o[1]),
    .sum_full(full_o[1]), .sum_num(num_o[1])
  );

  task automatic chk(input string tag, input int w, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[dut%0d]: observed=%0h expected=%0h", tag, w, obs, exp);
    end
  endtask

  function automatic bit elig_f(input int w, input int st, input int cur);
    if (w == 1) return ((cur - st) & 32'hFFFF) < 32'h8000;
    return st <= cur;
  endfunction

  // Reference behaviour of one list on one operation.
  task automatic model_op(input int w, input int typ, input int id, input int rank,
                          input int st, input int cur, output bit err, output ent_t r);
    ent_t e;
    int   p;
    err = 1'b1;
    r   = '0;
    e.id = 6'(id); e.rank = 16'(rank); e.st = 16'(st);
    case (typ)
      0: if (mq[w].size() < DEPTH) begin
           p = mq[w].size();
           for (int i = 0; i < mq[w].size(); i++)
             if (int'(mq[w][i].rank) > rank) begin p = i; break; end
           mq[w].insert(p, e);
           err = 1'b0; r = e;
         end
      1: for (int i = 0; i < mq[w].size(); i++)
           if (elig_f(w, int'(mq[w][i].st), cur)) begin
             r = mq[w][i]; mq[w].delete(i); err = 1'b0; break;
           end
      2: for (int i = 0; i < mq[w].size(); i++)
           if (int'(mq[w][i].id) == id) begin
             r = mq[w][i]; mq[w].delete(i); err = 1'b0; break;
           end
      default: ;
    endcase
  endtask

  task automatic chk_sums(input string tag, input int w);
    logic [15:0] mr, mt;
    mr = 16'hFFFF; mt = 16'hFFFF;
    if (mq[w].size() > 0) mr = mq[w][0].rank;
    foreach (mq[w][i]) if (mq[w][i].st < mt) mt = mq[w][i].st;
    chk({tag, ".num"},   w, 32'(num_o[w]),  32'(mq[w].size()));
    chk({tag, ".full"},  w, 32'(full_o[w]), 32'(mq[w].size() == DEPTH));
    chk({tag, ".srank"}, w, 32'(srank_o[w]), 32'(mr));
    chk({tag, ".stime"}, w, 32'(stime_o[w]), 32'(mt));
  endtask

  task automatic do_op(input string tag, input int typ, input int id, input int rank,
                       input int st, input int cur);
    bit   e_err [2];
    ent_t e_r   [2];
    int   k;
    @(negedge clk);
    for (int w = 0; w < 2; w++) chk({tag, ".ready"}, w, 32'(op_ready_o[w]), 32'd1);
    op_valid = 1'b1; op_type = 2'(typ); op_id = 6'(id); op_rank = 16'(rank);
    op_send_time = 16'(st); cur_time = 16'(cur);
    @(posedge clk); #1;
    op_valid = 1'b0;
    cur_time = 16'($urandom);
    for (int w = 0; w < 2; w++) model_op(w, typ, id, rank, st, cur, e_err[w], e_r[w]);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!res_valid_o[0] && k < 6);
    chk({tag, ".latency"}, 0, 32'(k), 32'd2);
    for (int w = 0; w < 2; w++) begin
      chk({tag, ".valid"}, w, 32'(res_valid_o[w]), 32'd1);
      chk({tag, ".err"},   w, 32'(res_err_o[w]),   32'(e_err[w]));
      chk({tag, ".id"},    w, 32'(res_id_o[w]),    32'(e_r[w].id));
      chk({tag, ".rank"},  w, 32'(res_rank_o[w]),  32'(e_r[w].rank));
      chk({tag, ".time"},  w, 32'(res_time_o[w]),  32'(e_r[w].st));
      chk_sums(tag, w);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (res_valid_o[0] || res_valid_o[1]) seen = 1'b1;
    end
    chk(tag, 0, 32'(seen), 32'd0);
  endtask

  task automatic do_flush(input string tag);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mq[w].delete();
      chk_sums(tag, w);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk({tag, ".ready"}, w, 32'(op_ready_o[w]),  32'd1);
      chk({tag, ".valid"}, w, 32'(res_valid_o[w]), 32'd0);
      chk({tag, ".err"},   w, 32'(res_err_o[w]),   32'd0);
      chk({tag, ".id"},    w, 32'(res_id_o[w]),    32'd0);
      chk({tag, ".rank"},  w, 32'(res_rank_o[w]),  32'd0);
      chk({tag, ".time"},  w, 32'(res_time_o[w]),  32'd0);
      mq[w].delete();
      chk_sums(tag, w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0; op_type = '0; op_id = '0;
    op_rank = '0; op_send_time = '0; cur_time = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b1;

    // Sorted insert with ties kept in arrival order, then drain in order.
    do_op("enq_a", 0, 1, 5, 10, 0);
    do_op("enq_b", 0, 2, 3, 20, 0);
    do_op("enq_c", 0, 7, 5, 30, 0);
    do_op("enq_d", 0, 4, 1, 40, 0);
    repeat (4) do_op("drain", 1, 0, 0, 0, 100);
    do_op("deq_empty", 1, 0, 0, 0, 100);
    do_op("rsvd", 3, 1, 1, 1, 1);

    // Full list and overflow.
    for (int i = 0; i < DEPTH; i++) do_op("fill", 0, i, 20 - i, i * 3, 0);
    do_op("enq_full", 0, 33, 1, 1, 0);
    do_op("rsvd_full", 3, 0, 0, 0, 0);
    do_flush("flush1");

    // Eligibility picks a later slot; nothing eligible afterwards.
    do_op("e25a", 0, 1, 2, 50, 0);
    do_op("e25b", 0, 2, 4, 10, 0);
    do_op("elig20", 1, 0, 0, 0, 20);
    do_op("elig5", 1, 0, 0, 0, 5);
    do_flush("flush2");

    // Wrap-around time: only the wrap-aware engine sees it eligible.
    do_op("wrap_enq", 0, 9, 1, 16'hFFF0, 0);
    do_op("wrap_deq", 1, 0, 0, 0, 16'h0010);
    do_flush("flush3");

    // Dequeue by id: hit mid-list, repeat miss, drain.
    for (int i = 0; i < 5; i++) do_op("id_fill", 0, 10 + i, 10 + i, 60 - i, 0);
    do_op("id_hit", 2, 12, 0, 0, 0);
    do_op("id_miss", 2, 12, 0, 0, 0);
    repeat (4) do_op("id_drain", 1, 0, 0, 0, 100);

    // Flush one cycle after accept aborts the op.
    do_op("pre_flush", 0, 3, 3, 3, 0);
    @(negedge clk);
    op_valid = 1'b1; op_type = 2'd0; op_id = 6'd5; op_rank = 16'd5; op_send_time = 16'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int w = 0; w < 2; w++) begin mq[w].delete(); chk_sums("flush_inflight", w); end
    expect_quiet("flush_inflight.noresult", 4);

    // Flush together with a request: not accepted, dropped.
    do_op("pre_flush2", 0, 3, 3, 3, 0);
    @(negedge clk);
    op_valid = 1'b1; op_type = 2'd0; op_id = 6'd6; op_rank = 16'd6; op_send_time = 16'd6;
    flush = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) chk("flush_accept.ready", w, 32'(op_ready_o[w]), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    for (int w = 0; w < 2; w++) begin mq[w].delete(); chk_sums("flush_accept", w); end
    expect_quiet("flush_accept.noresult", 4);

    // Reset in the middle of an op.
    do_op("pre_rst", 0, 8, 8, 8, 0);
    @(negedge clk);
    op_valid = 1'b1; op_type = 2'd1; cur_time = 16'd100;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_reset_state("rst_mid");
    expect_quiet("rst_mid.noresult", 4);

    // Randomized traffic with frequent rank ties and id collisions.
    for (int n = 0; n < 150; n++) begin
      int r, typ;
      r = int'($urandom_range(0, 9));
      typ = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      do_op("rand", typ, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 100)), int'($urandom_range(0, 120)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pieo_sublist_engine.md
PIEO_SUBLIST_ENGINE -- requirements
Module: pieo_sublist_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per sublist; power of 2, >=2.
REQ-002 SHALL have parameter ID_W, default 6, element id width.
REQ-003 SHALL have parameter RANK_W, default 16, rank width; all-ones = infinity.
REQ-004 SHALL have parameter TIME_W, default 16, send_time width; all-ones = infinity.
REQ-005 SHALL have parameter WRAP_TIME, default 0; 1 = wrap-aware eligibility compare.
REQ-006 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  clear all entries.
- op_valid  in  1  operation request.
- op_ready  out  1  engine idle, can accept.
- op_type  in  2  0=ENQ, 1=DEQ_ELIG, 2=DEQ_ID, 3=reserved.
- op_id  in  ID_W  element id (ENQ, DEQ_ID).
- op_rank  in  RANK_W  rank (ENQ).
- op_send_time  in  TIME_W  send time (ENQ).
- cur_time  in  TIME_W  current time (DEQ_ELIG).
- res_valid  out  1  one-cycle result strobe.
- res_err  out  1  operation failed.
- res_id  out  ID_W  result element id.
- res_rank  out  RANK_W  result element rank.
- res_send_time  out  TIME_W  result element send time.
- sum_smallest_rank  out  RANK_W  rank of head entry.
- sum_smallest_send_time  out  TIME_W  min send_time over valid entries.
- sum_full  out  1  num == DEPTH.
- sum_num  out  $clog2(DEPTH+1)  valid entry count.

Function
REQ-007 SHALL store entries sorted by rank ascending in slots 0..num-1; equal ranks SHALL keep insertion order (new entry behind equals).
REQ-008 SHALL accept an op when op_valid && op_ready; FSM IDLE -> SEARCH -> UPDATE -> IDLE; op_ready high only in IDLE.
REQ-009 SEARCH SHALL register the position/match vector; UPDATE SHALL shift storage, update summaries and pulse res_valid; latency accept-edge to res_valid = 2 cycles.
REQ-010 ENQ SHALL insert at the first slot whose rank > op_rank, shifting later slots up; res_id/res_rank/res_send_time echo the inserted element.
REQ-011 ENQ when full SHALL set res_err=1 and leave storage unchanged.
REQ-012 DEQ_ELIG SHALL remove the lowest-index eligible entry and shift later slots down; eligible = send_time <= cur_time (WRAP_TIME=0) or (cur_time - send_time) mod 2^TIME_W < 2^(TIME_W-1) (WRAP_TIME=1).
REQ-013 DEQ_ELIG with empty list or no eligible entry SHALL set res_err=1, no change.
REQ-014 DEQ_ID SHALL remove the lowest-index entry whose id == op_id; miss SHALL set res_err=1, no change.
REQ-015 op_type 3 SHALL complete with res_err=1, no change.
REQ-016 On res_err=1, res_id/res_rank/res_send_time SHALL be all-zero.
REQ-017 Summaries SHALL be registered and update on the UPDATE edge; empty list SHALL give sum_smallest_rank and sum_smallest_send_time = all-ones.
REQ-018 cur_time SHALL be sampled at the accept edge.
REQ-019 flush SHALL empty the list on the next edge, abort any in-flight op with no res_valid, and win over a simultaneous accept (op dropped); op_ready SHALL be low in the flush cycle.

Reset
REQ-020 rst low at a clock edge SHALL force IDLE, num=0, op_ready=1, res_valid=0, res_err=0, res outputs 0, sum_smallest_rank/time all-ones, sum_full=0; in-flight op aborted, no result.

Structure
REQ-021 Op type encoding and default width constants SHALL live in pieo_datatypes; the module SHALL use parameters, not package-fixed sizes.
REQ-022 Eligibility compare SHALL be one sub-module, pieo_time_cmp, parameterised by TIME_W and WRAP_TIME.

Verification
REQ-023 ENQ ranks 5,3,5(id 7),1 -> slot order ranks 1,3,5,5 with id 7 last; sum_num=4, sum_smallest_rank=1.
REQ-024 DEPTH=8 fill 8 ENQs -> sum_full=1; 9th ENQ -> res_err=1, sum_num stays 8.
REQ-025 Entries (rank 2,t=50),(rank 4,t=10); DEQ_ELIG cur_time=20 -> returns rank 4; cur_time=5 on remaining -> res_err=1.
REQ-026 WRAP_TIME=1, TIME_W=16, send_time=0xFFF0, cur_time=0x0010 -> eligible; WRAP_TIME=0 same stimulus -> res_err=1.
REQ-027 DEQ_ID hit mid-list -> later slots shift down, sum_num decrements; DEQ_ID miss -> res_err=1.
REQ-028 flush asserted one cycle after ENQ accept -> no res_valid, sum_num=0; rst low mid-op -> REQ-020 values next edge.
